board_win_scanner: RTL and testbench

//  Sequential five-in-a-row checker for the 16x16 Gomoku board. Snapshots the packed
//  2-bit/cell board written by the put path and walks every cell as a run origin, one

---
 rtl/board_win_scanner.sv | 125 ++++++++++++
 tb/tb_board_win_scanner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/board_win_scanner.sv
// board_win_scanner: sequential five-in-a-row scan of a snapshotted Gomoku board, one origin cell per clock.
module board_win_scanner #(
  parameter int BOARD_N = 16,
  parameter int COORD_W = 4,
  parameter int RUN_LEN = 5
) (
  input  logic                           clock_i,
  input  logic                           resetn_i,
  input  logic                           start_i,
  input  logic [2*BOARD_N*BOARD_N-1:0]   board_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [1:0]                     result_o,
  output logic [COORD_W-1:0]             win_x_o,
  output logic [COORD_W-1:0]             win_y_o,
  output logic [1:0]                     win_dir_o
);
  localparam int IDX_W = 2 * COORD_W;
  localparam logic [COORD_W-1:0] LIM_HI = COORD_W'(BOARD_N - RUN_LEN);
  localparam logic [COORD_W-1:0] LIM_LO = COORD_W'(RUN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [2*BOARD_N*BOARD_N-1:0]   snap_q, snap_d;
  logic [1:0]                     result_q, result_d;
  logic [COORD_W-1:0]             wx_q, wx_d, wy_q, wy_d;
  logic [1:0]                     wdir_q, wdir_d;
  logic                           busy_q, busy_d, done_q, done_d;

  logic [COORD_W-1:0] ox, oy, cx, cy;
  logic [1:0]         org;
  logic [3:0]         in_b, hit;
  logic [1:0]         hit_dir;

  assign ox = idx_q[IDX_W-1:COORD_W];
  assign oy = idx_q[COORD_W-1:0];

  // Cell coordinates wrap in 4-bit arithmetic; in_b masks any origin whose run would leave the board.
  always_comb begin
    cx = '0;
    cy = '0;
    org = snap_q[{idx_q, 1'b0} +: 2];
    in_b[0] = oy <= LIM_HI;
    in_b[1] = ox <= LIM_HI;
    in_b[2] = ox <= LIM_HI && oy <= LIM_HI;
    in_b[3] = ox <= LIM_HI && oy >= LIM_LO;
    for (int d = 0; d < 4; d++) begin
      hit[d] = in_b[d] && (org == 2'b01 || org == 2'b10);
      for (int k = 1; k < RUN_LEN; k++) begin
        cx = (d == 0) ? ox : ox + COORD_W'(k);
        cy = (d == 1) ? oy : (d == 3) ? oy - COORD_W'(k) : oy + COORD_W'(k);
        hit[d] = hit[d] && (snap_q[{cx, cy, 1'b0} +: 2] == org);
      end
    end
    hit_dir = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    result_d = result_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    wdir_d   = wdir_q;
    case (state_q)
      IDLE: if (start_i) begin
        snap_d   = board_i;
        idx_d    = '0;
        result_d = 2'b00;
        wx_d     = '0;
        wy_d     = '0;
        wdir_d   = 2'd0;
        state_d  = SCAN;
      end
      SCAN: if (|hit) begin
        result_d = org;
        wx_d     = ox;
        wy_d     = oy;
        wdir_d   = hit_dir;
        state_d  = DONE;
      end else if (&idx_q) begin
        state_d = DONE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == SCAN;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      snap_q   <= '0;
      result_q <= 2'b00;
      wx_q     <= '0;
      wy_q     <= '0;
      wdir_q   <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      result_q <= result_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      wdir_q   <= wdir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign win_x_o   = wx_q;
  assign win_y_o   = wy_q;
  assign win_dir_o = wdir_q;
endmodule

// File: tb/tb_board_win_scanner.sv
// tb_board_win_scanner: table-driven scans with a scoreboard of expected results plus multi-cycle corner sequences.
module tb_board_win_scanner;
  localparam int N = 16;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] board = '0;
  logic         busy, done;
  logic [1:0]   result, win_dir;
  logic [3:0]   win_x, win_y;

  board_win_scanner dut (
    .clock_i(clk), .resetn_i(rst_n), .start_i(start), .board_i(board),
    .busy_o(busy), .done_o(done), .result_o(result),
    .win_x_o(win_x), .win_y_o(win_y), .win_dir_o(win_dir)
  );

  always #5 clk = ~clk;

  typedef struct {logic [511:0] b; logic [1:0] r; int x; int y; int d;} vec_t;
  typedef struct {logic [1:0] r; int x; int y; int d; int lat;} exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vt[$];

  function automatic logic [511:0] put(input logic [511:0] b, input logic [1:0] v,
                                       input int x, input int y, input int dx, input int dy, input int n);
    logic [511:0] r = b;
    for (int k = 0; k < n; k++) r[2*(N*(x+k*dx)+(y+k*dy)) +: 2] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t t);
    exp_t e;
    e.r = t.r; e.x = t.x; e.y = t.y; e.d = t.d;
    e.lat = (t.r != 2'b00) ? t.x*N + t.y + 1 : 256;
    sb.push_back(e);
  endtask

  // Counts edges after the start edge until done; mode 1 flips the board and pokes start during the scan.
  task automatic wait_done(input int mode, output int cnt, output int bc);
    cnt = 0;
    bc = 0;
    while (!done && cnt < 400) begin
      if (busy) bc++;
      if (mode == 1) begin
        if (cnt == 20) board = '0;
        start = (cnt == 30 || cnt == 60 || cnt == 84);
      end
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_pop(input string nm, input int cnt, input int bc);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_result"}, int'(result), int'(e.r));
    chk({nm, "_x"}, int'(win_x), e.x);
    chk({nm, "_y"}, int'(win_y), e.y);
    chk({nm, "_dir"}, int'(win_dir), e.d);
    chk({nm, "_latency"}, cnt, e.lat);
    chk({nm, "_busy_cycles"}, bc, e.lat);
  endtask

  task automatic launch(input logic [511:0] b, input logic hold);
    board = b;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = hold;
  endtask

  task automatic count_done(input int cycles, output int dc);
    dc = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
  endtask

  initial begin
    int cnt, bc, dc;
    logic [511:0] b;
    vt.push_back('{b: '0, r: 2'b00, x: 0, y: 0, d: 0});
    vt.push_back('{b: put('0, 2'b01, 3, 2, 0, 1, 5), r: 2'b01, x: 3, y: 2, d: 0});
    vt.push_back('{b: put('0, 2'b10, 0, 15, 1, -1, 5), r: 2'b10, x: 0, y: 15, d: 3});
    vt.push_back('{b: put(put('0, 2'b01, 2, 12, 0, 1, 4), 2'b01, 3, 0, 0, 1, 1), r: 2'b00, x: 0, y: 0, d: 0});
    vt.push_back('{b: put(put('0, 2'b01, 7, 3, 0, 1, 4), 2'b10, 7, 7, 0, 1, 1), r: 2'b00, x: 0, y: 0, d: 0});
    vt.push_back('{b: put('0, 2'b10, 0, 0, 1, 0, 5), r: 2'b10, x: 0, y: 0, d: 1});
    vt.push_back('{b: put('0, 2'b01, 11, 11, 1, 1, 5), r: 2'b01, x: 11, y: 11, d: 2});
    vt.push_back('{b: put('0, 2'b11, 1, 0, 0, 1, 5), r: 2'b00, x: 0, y: 0, d: 0});
    vt.push_back('{b: put(put('0, 2'b10, 0, 3, 1, -1, 4), 2'b10, 4, 15, 0, 1, 1), r: 2'b00, x: 0, y: 0, d: 0});
    vt.push_back('{b: put(put('0, 2'b10, 9, 0, 0, 1, 5), 2'b01, 2, 7, 0, 1, 5), r: 2'b01, x: 2, y: 7, d: 0});
    vt.push_back('{b: put(put('0, 2'b01, 5, 5, 0, 1, 5), 2'b01, 5, 5, 1, 0, 5), r: 2'b01, x: 5, y: 5, d: 0});
    vt.push_back('{b: put('0, 2'b01, 15, 11, 0, 1, 5), r: 2'b01, x: 15, y: 11, d: 0});

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_x", int'(win_x), 0);
    chk("rst_y", int'(win_y), 0);
    chk("rst_dir", int'(win_dir), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      push_exp(vt[i]);
      launch(vt[i].b, 1'b0);
      wait_done(0, cnt, bc);
      check_pop($sformatf("vec%0d", i), cnt, bc);
      repeat (3) @(posedge clk);
    end

    // Board changed mid-scan and start poked during SCAN and DONE: one result, one done.
    push_exp(vt[10]);
    launch(vt[10].b, 1'b0);
    wait_done(1, cnt, bc);
    check_pop("midchange", cnt, bc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count_done(300, dc);
    chk("ignored_start_dones", dc, 0);
    chk("ignored_start_busy", int'(busy), 0);

    // Start held high: scan restarts right after DONE, outputs cleared on acceptance.
    push_exp(vt[2]);
    push_exp(vt[2]);
    launch(vt[2].b, 1'b1);
    wait_done(0, cnt, bc);
    start = 1'b1;
    check_pop("held_first", cnt, bc);
    cnt = 0;
    bc = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (busy && bc == 0) chk("held_cleared_result", int'(result), 0);
      if (busy) bc++;
    end while (!done && cnt < 400);
    start = 1'b0;
    chk("held_restart_gap", cnt, 18);
    check_pop("held_second", cnt - 2, bc);
    count_done(300, dc);
    chk("held_release_dones", dc, 0);

    // Reset mid-scan at idx 100 aborts without a done pulse.
    b = put('0, 2'b01, 14, 11, 0, 1, 5);
    launch(b, 1'b0);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_x", int'(win_x), 0);
    chk("abort_y", int'(win_y), 0);
    chk("abort_dir", int'(win_dir), 0);
    @(negedge clk) rst_n = 1'b1;
    count_done(300, dc);
    chk("abort_dones", dc, 0);
    push_exp(vt[11]);
    launch(vt[11].b, 1'b0);
    wait_done(0, cnt, bc);
    check_pop("after_abort", cnt, bc);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
